// File: rtl/imu_poll_sequencer_if.sv
// Transaction bus between the IMU poll sequencer and the I2C byte core.
interface imu_poll_sequencer_if;
  logic       data_valid;
  logic       rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       core_busy;
  logic [7:0] core_rd_data;

  modport master (
    output data_valid, rw, slave_addr, reg_addr, reg_data,
    input  core_busy, core_rd_data
  );

  modport slave (
    input  data_valid, rw, slave_addr, reg_addr, reg_data,
    output core_busy, core_rd_data
  );
endinterface

// File: rtl/imu_poll_sequencer.sv
// Configures an MPU-class IMU at 0x68, then polls the six gyro bytes each POLL_DIV
// cycles and publishes complete X/Y/Z samples atomically.
module imu_poll_sequencer #(
  parameter int unsigned POLL_DIV = 500000,
  parameter int unsigned TIMEOUT  = 2000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  imu_poll_sequencer_if.master        core,
  output logic [15:0]                 gyro_x,
  output logic [15:0]                 gyro_y,
  output logic [15:0]                 gyro_z,
  output logic                        sample_valid,
  output logic                        init_done,
  output logic                        err
);
  localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, ACK_WAIT, DONE_WAIT, POLL_WAIT, PUBLISH, ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic            init_done_q, init_done_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [15:0]     gx_q, gx_d, gy_q, gy_d, gz_q, gz_d;
  logic            sv_q, sv_d;
  logic            issue;
  logic            active;
  logic            timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      poll_q      <= '0;
      tmr_q       <= '0;
      shadow_q    <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      gz_q        <= '0;
      sv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      poll_q      <= poll_d;
      tmr_q       <= tmr_d;
      shadow_q    <= shadow_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      gz_q        <= gz_d;
      sv_q        <= sv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    abort_d     = abort_q;
    poll_d      = poll_q;
    tmr_d       = tmr_q;
    shadow_d    = shadow_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    gz_d        = gz_q;
    sv_d        = 1'b0;
    issue       = 1'b0;
    // Timer counts cycles since the data_valid cycle; value k is reached k cycles later.
    timed_out   = (tmr_q >= TW'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        if (enable) state_d = ISSUE;
      end
      ISSUE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!core.core_busy) begin
          issue   = 1'b1;
          tmr_d   = TW'(1);
          state_d = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (!enable) abort_d = 1'b1;
        if (timed_out) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (core.core_busy) state_d = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        if (!enable) abort_d = 1'b1;
        if (timed_out) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else if (!core.core_busy) begin
          tmr_d = '0;
          if (step_q >= 3'd2) shadow_d[step_q - 3'd2] = core.core_rd_data;
          if (abort_q || !enable) begin
            state_d = IDLE;
          end else if (step_q == 3'd1) begin
            init_done_d = 1'b1;
            step_d      = 3'd2;
            poll_d      = PW'(POLL_DIV - 1);
            state_d     = POLL_WAIT;
          end else if (step_q == 3'd7) begin
            state_d = PUBLISH;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ISSUE;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      POLL_WAIT: begin
        if (!enable)             state_d = IDLE;
        else if (poll_q == '0)   state_d = ISSUE;
        else                     poll_d  = poll_q - PW'(1);
      end
      PUBLISH: begin
        gx_d    = {shadow_q[0], shadow_q[1]};
        gy_d    = {shadow_q[2], shadow_q[3]};
        gz_d    = {shadow_q[4], shadow_q[5]};
        sv_d    = 1'b1;
        step_d  = 3'd2;
        poll_d  = PW'(POLL_DIV - 1);
        state_d = POLL_WAIT;
      end
      ERROR: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Every path into IDLE shares one cleanup so entry always restarts the config sequence.
    if (state_d == IDLE && state_q != IDLE) begin
      step_d      = '0;
      init_done_d = 1'b0;
      abort_d     = 1'b0;
      poll_d      = '0;
      tmr_d       = '0;
    end
  end

  always_comb begin
    active          = (state_q == ISSUE) || (state_q == ACK_WAIT) || (state_q == DONE_WAIT);
    core.rw         = 1'b0;
    core.slave_addr = '0;
    core.reg_addr   = '0;
    core.reg_data   = '0;
    if (active) begin
      core.slave_addr = 7'h68;
      case (step_q)
        3'd0: begin
          core.reg_addr = 8'h6B;
          core.reg_data = 8'h01;
        end
        3'd1: core.reg_addr = 8'h1B;
        default: begin
          core.rw       = 1'b1;
          core.reg_addr = 8'h41 + {5'd0, step_q};
        end
      endcase
    end
  end

  assign core.data_valid = issue;
  assign gyro_x          = gx_q;
  assign gyro_y          = gy_q;
  assign gyro_z          = gz_q;
  assign sample_valid    = sv_q;
  assign init_done       = init_done_q;
  assign err             = err_q;
endmodule
